// File: rtl/audio_eth_pkg.sv
// Shared types and constants for the audio-over-Ethernet packet scheduler.
package audio_eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SEND,
    ST_WAIT_DONE,
    ST_GAP
  } state_t;

  localparam int PKT_LEN_DEF = 1024;
  localparam int GAP_CYC_DEF = 12;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant: on a tie the side not served last wins.
module rr_arb2
  import audio_eth_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       gnt_valid
);

  assign gnt_valid = |req;
  assign gnt       = (&req) ? ~last : req[CH_R];

endmodule

// File: rtl/audio_pkt_sched.sv
// Schedules fixed-size L/R audio payloads from two read FIFOs into a UDP TX
// engine: arbitrate, request, stream PKT_LEN bytes, await done, enforce a gap.
module audio_pkt_sched
  import audio_eth_pkg::*;
#(
  parameter int PKT_LEN = PKT_LEN_DEF,
  parameter int LVL_W   = 11,
  parameter int GAP_CYC = GAP_CYC_DEF,
  parameter int REQ_TMO = 65535
) (
  input  logic             gmii_rx_clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [LVL_W-1:0] l_level,
  input  logic [7:0]       l_data,
  output logic             l_rd_en,
  input  logic [LVL_W-1:0] r_level,
  input  logic [7:0]       r_data,
  output logic             r_rd_en,
  output logic             tx_req,
  input  logic             tx_ack,
  input  logic             tx_data_req,
  output logic [7:0]       tx_data,
  output logic             tx_chan,
  input  logic             tx_done,
  output logic             busy,
  output logic [15:0]      pkt_cnt,
  output logic             err
);

  localparam int BW = $clog2(PKT_LEN + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int TW = $clog2(REQ_TMO + 1);
  localparam logic [BW-1:0] PKT_LEN_C = BW'(PKT_LEN);
  localparam logic [BW-1:0] LAST_BYTE = BW'(PKT_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(REQ_TMO - 1);

  state_t        state;
  logic [BW-1:0] byte_cnt;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          last_served, rd_vld, gnt, gnt_valid, rd_ok, rd_en;
  logic [1:0]    elig;

  // Levels are widened, never truncated, so an unreachable PKT_LEN never grants.
  assign elig = {32'(r_level) >= PKT_LEN, 32'(l_level) >= PKT_LEN};

  rr_arb2 u_arb (
    .req      (elig),
    .last     (last_served),
    .gnt      (gnt),
    .gnt_valid(gnt_valid)
  );

  assign rd_ok   = (state == ST_SEND) && (byte_cnt < PKT_LEN_C);
  assign rd_en   = rst_n && !flush && tx_data_req && rd_ok;
  assign l_rd_en = rd_en && (tx_chan == CH_L);
  assign r_rd_en = rd_en && (tx_chan == CH_R);
  // FIFO data is only meaningful the cycle after a read; hold 0 otherwise.
  assign tx_data = !rd_vld ? 8'h00 : (tx_chan == CH_R) ? r_data : l_data;
  assign tx_req  = (state == ST_REQ);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge gmii_rx_clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      tx_chan     <= CH_L;
      last_served <= CH_R;
      pkt_cnt     <= '0;
      err         <= 1'b0;
      byte_cnt    <= '0;
      gap_cnt     <= '0;
      tmo_cnt     <= '0;
      rd_vld      <= 1'b0;
    end else begin
      rd_vld <= rd_en;
      if (tx_data_req && !rd_ok) err <= 1'b1;
      if (flush) begin
        state    <= ST_IDLE;
        byte_cnt <= '0;
        gap_cnt  <= '0;
        tmo_cnt  <= '0;
      end else begin
        unique case (state)
          ST_IDLE: if (gnt_valid) begin
            tx_chan <= gnt;
            tmo_cnt <= '0;
            state   <= ST_REQ;
          end
          ST_REQ: if (tx_ack) begin
            byte_cnt <= '0;
            tmo_cnt  <= '0;
            state    <= ST_SEND;
          end else if (tmo_cnt == TMO_LAST) begin
            err     <= 1'b1;
            tmo_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
          ST_SEND: begin
            if (rd_en) byte_cnt <= byte_cnt + 1'b1;
            // An early done abandons the packet without counting it.
            if (tx_done) begin
              err     <= 1'b1;
              gap_cnt <= '0;
              state   <= ST_GAP;
            end else if (rd_en && byte_cnt == LAST_BYTE) begin
              state <= ST_WAIT_DONE;
            end
          end
          ST_WAIT_DONE: if (tx_done) begin
            pkt_cnt     <= pkt_cnt + 1'b1;
            last_served <= tx_chan;
            gap_cnt     <= '0;
            state       <= ST_GAP;
          end
          ST_GAP: if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/audio_pkt_sched.md
AUDIO_PKT_SCHED -- requirements
Module: audio_pkt_sched

Interface
REQ-001 SHALL have parameters: PKT_LEN, default 1024, payload bytes per UDP packet; LVL_W, default 11, FIFO water-level width; GAP_CYC, default 12, minimum idle cycles between packets; REQ_TMO, default 65535, cycles to wait for tx_ack.
REQ-002 SHALL have ports, one per line:
- gmii_rx_clk  in  1  sole clock (FIFO read domain)
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  frame-boundary abort (voice_vsync), synchronous to gmii_rx_clk
- l_level  in  LVL_W  left FIFO rd water level
- l_data  in  8  left FIFO rd_data, valid 1 cycle after l_rd_en
- l_rd_en  out  1  left FIFO read strobe
- r_level  in  LVL_W  right FIFO rd water level
- r_data  in  8  right FIFO rd_data
- r_rd_en  out  1  right FIFO read strobe
- tx_req  out  1  packet start request to UDP TX
- tx_ack  in  1  UDP TX accepted the request (1-cycle pulse)
- tx_data_req  in  1  UDP TX wants next payload byte
- tx_data  out  8  payload byte, 1 cycle after tx_data_req
- tx_chan  out  1  channel of current packet: 0 = L, 1 = R
- tx_done  in  1  UDP TX finished frame (1-cycle pulse)
- busy  out  1  high in any state other than IDLE
- pkt_cnt  out  16  packets completed, wraps
- err  out  1  sticky error flag

Function
REQ-003 SHALL implement FSM IDLE, REQ, SEND, WAIT_DONE, GAP.
REQ-004 Eligibility: L when l_level >= PKT_LEN, R when r_level >= PKT_LEN; compare at LVL_W bits, no truncation.
REQ-005 IDLE: if any channel is eligible, latch the grant into tx_chan and go to REQ the next cycle; else remain in IDLE.
REQ-006 Arbitration round-robin: if both are eligible, grant the channel opposite last_served; after reset last_served = R, so L wins the first tie.
REQ-007 REQ: tx_req held high; on tx_ack go to SEND, byte count = 0, tx_req low the next cycle.
REQ-008 REQ timeout: after REQ_TMO cycles without tx_ack, set err, deassert tx_req and return to IDLE; last_served unchanged.
REQ-009 SEND: x_rd_en = tx_data_req AND (byte count < PKT_LEN) for the granted channel only, combinational; the other rd_en stays 0.
REQ-010 tx_data SHALL be the granted channel's rd_data, muxed from tx_chan; latency is 1 cycle from tx_data_req.
REQ-011 Byte count increments on each rd_en; when it reaches PKT_LEN, go to WAIT_DONE.
REQ-012 tx_data_req while byte count == PKT_LEN, or outside SEND, SHALL produce no rd_en and SHALL set err.
REQ-013 WAIT_DONE: on tx_done, increment pkt_cnt (mod 2^16), set last_served = tx_chan and go to GAP.
REQ-014 tx_done arriving in SEND before PKT_LEN bytes: set err, go to GAP, pkt_cnt unchanged.
REQ-015 GAP: count GAP_CYC cycles, then go to IDLE; no tx_req is raised in GAP.
REQ-016 flush has priority over every other event: next state IDLE, tx_req = 0, rd_en = 0, byte/gap/timeout counters cleared; pkt_cnt, err and last_served kept.
REQ-017 rd_en SHALL never be asserted in the cycle flush is high.

Reset
REQ-018 While rst_n = 0 at a clock edge: state IDLE, tx_req = 0, l_rd_en = r_rd_en = 0, tx_chan = 0, busy = 0, pkt_cnt = 0, err = 0, last_served = R, all counters 0, tx_data = 0.
REQ-019 rst_n overrides flush; reset mid-packet SHALL abandon the packet without rd_en.

Structure
REQ-020 Package audio_eth_pkg SHALL hold the FSM state encoding, PKT_LEN/GAP_CYC defaults and the channel-id constants (CH_L = 0, CH_R = 1).
REQ-021 Sub-module rr_arb2 SHALL hold the 2-requester round-robin grant (inputs: req[1:0], last; outputs: gnt, gnt_valid); everything else stays in audio_pkt_sched.

Verification
REQ-022 l_level = 1024, r_level = 0; ack after 3 cycles; tx_data_req for 1024 cycles; then tx_done -> exactly 1024 l_rd_en, 0 r_rd_en, tx_chan = 0, pkt_cnt = 1, err = 0.
REQ-023 Both levels held at 2000; 4 packets -> tx_chan sequence 0, 1, 0, 1; ≥ 12 idle cycles between tx_done and the next tx_req.
REQ-024 flush in SEND after 500 bytes -> same-cycle rd_en = 0, next cycle IDLE, pkt_cnt unchanged, new packet restarts from byte 0.
REQ-025 l_level = 1023 -> no tx_req; raise to 1024 -> tx_req 2 cycles later.
REQ-026 Never ack, REQ_TMO = 16 -> tx_req drops after 16 cycles, err = 1, busy = 0.
REQ-027 1025th tx_data_req in a packet -> no rd_en, err = 1; rst_n low mid-SEND -> all outputs at REQ-018 values.
